sbus_channel_poller: RTL
========================

// Module: sbus_channel_poller
// PURPOSE
//  Avalon-MM master that periodically sweeps NUM_CH sbus decoder input channels (PIO-style,
//  registered readdata at offset 0), compares each sample with a shadow copy, and queues
//  change events {channel, new value} in a FIFO. A CPU drains the FIFO through a 4-word CSR
//  slave and is interrupted while events are pending. This removes per-channel CPU polling.
// PARAMETERS
//  NUM_CH      4      channels swept, indices 0..NUM_CH-1 (max 16)
//  BASE_ADDR   32'h0  byte address of channel 0
//  CH_STRIDE   16     byte address stride between channels
//  DATA_W      11     significant low bits of each channel's readdata
//  FIFO_DEPTH  8      event FIFO entries (power of 2)
//  PERIOD_RST  50000  reset value of the PERIOD CSR (cycles between sweep starts)
// PORTS
//  clk              in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  m_address        out  32  master byte address
//  m_read           out  1   master read request
//  m_waitrequest    in   1   slave stall; m_read/m_address held while high
//  m_readdata       in   32  read data
//  m_readdatavalid  in   1   read data valid
//  s_address        in   2   CSR word select
//  s_read           in   1   CSR read strobe
//  s_write          in   1   CSR write strobe
//  s_writedata      in   32  CSR write data
//  s_readdata       out  32  CSR read data, registered, valid 1 cycle after s_read
//  irq              out  1   level interrupt
// BEHAVIOUR
//  Reset: m_read=0, m_address=BASE_ADDR, s_readdata=0, irq=0; CTRL=0, PERIOD=PERIOD_RST,
//   FIFO empty, overflow=0, shadow_valid=0, tick counter=0, FSM=IDLE.
//  CSR map: 0 CTRL rw {bit1 irq_en, bit0 enable}; 1 STATUS ro/W1C {[15:8] fifo count,
//   bit1 overflow (sticky, write 1 clears), bit0 nonempty}; 2 EVENT ro, read pops FIFO,
//   {[27:24] ch, [DATA_W-1:0] value}, all else 0; read when empty returns 0, no pop;
//   3 PERIOD rw [31:0], value 0 treated as 1.
//  FSM: IDLE -(enable)-> WAIT_TICK; tick counter counts to PERIOD-1 then -> ISSUE, ch=0.
//   ISSUE: m_read=1, m_address=BASE_ADDR+ch*CH_STRIDE; leave on cycle with m_waitrequest=0
//   -> WAIT_DATA. WAIT_DATA: on m_readdatavalid capture m_readdata[DATA_W-1:0] -> COMPARE.
//   COMPARE (1 cycle): if shadow_valid and sample!=shadow[ch] push {ch,sample}; shadow[ch]<=sample.
//   Then ch<NUM_CH-1 -> ISSUE ch+1, else set shadow_valid, -> WAIT_TICK (or IDLE if !enable).
//  Tick counter runs free from entering WAIT_TICK; sweep start spacing = max(PERIOD, sweep time).
//  First sweep after reset or after enable 0->1 only loads shadow (shadow_valid cleared on
//   enable rising edge): no events.
//  Clearing enable mid-sweep: an accepted read completes (data discarded, no push), then IDLE;
//   a request not yet accepted is held until accepted (Avalon rule), then same.
//  FIFO full on push: event dropped, overflow set. Same-cycle pop and push when full: both
//   occur, no overflow. Overflow set and W1C same cycle: set wins.
//  irq = irq_en & nonempty, registered (asserts 1 cycle after first push).
// STRUCTURE
//  Package sbus_poll_pkg: FSM state enum, CSR offset constants, EVENT field positions.
//  Sub-module sbus_event_fifo (sync FIFO, push/pop/full/empty/count, first-word fall-through).
// TESTING
//  Reset then enable, PERIOD=10, channels static 0x155 -> reads at ch 0,1,2,3 addrs 0,16,32,48;
//   two sweeps, no events, irq=0.
//  After baseline, ch2 changes to 0x7FF, irq_en=1 -> one event, EVENT read = 0x020007FF, irq
//   falls 1 cycle after pop; next EVENT read = 0.
//  m_waitrequest held high 5 cycles on ch1 -> m_read/m_address stable all 5, single read issued.
//  Toggle ch0 every sweep with no pops -> 8 events then overflow=1, count=8; W1C bit1 clears it.
//  Clear enable while WAIT_DATA on ch1 -> readdatavalid accepted, no push, FSM IDLE, m_read=0.
//  Assert reset mid-sweep -> all outputs/CSRs to reset values same cycle; re-enable gives
//   baseline-only sweep.

Source files
------------

// File: rtl/sbus_channel_poller_pkg.sv
// Shared types and constants for the sbus channel poller: sweep FSM states,
// CSR word offsets and EVENT word field layout.
package sbus_poll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_COMPARE
    } state_t;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_EVENT  = 2'd2;
    localparam logic [1:0] CSR_PERIOD = 2'd3;

    localparam int EV_CH_LSB     = 24;
    localparam int EV_CH_W       = 4;
    localparam int ST_COUNT_LSB  = 8;

    // value is already masked to DATA_W bits by the caller
    function automatic logic [31:0] ev_word(input logic [EV_CH_W-1:0] ch, input logic [31:0] value);
        return value | ({28'h0, ch} << EV_CH_LSB);
    endfunction

endpackage

// File: rtl/sbus_event_fifo.sv
// Synchronous first-word-fall-through FIFO; o_dat shows the head while not empty.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module sbus_event_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sbus_channel_poller.sv
// Avalon-MM master sweeping NUM_CH PIO channels every PERIOD cycles, queueing {ch, value}
// change events for a CPU behind a 4-word CSR slave; one read outstanding, holds on waitrequest.
module sbus_channel_poller
    import sbus_poll_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          CH_STRIDE  = 16,
    parameter int          DATA_W     = 11,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] PERIOD_RST = 32'd50000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EV_W     = EV_CH_W + DATA_W;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    state_t              r_state;
    logic [CH_IDX_W-1:0] r_ch;
    logic [DATA_W-1:0]   r_sample;
    logic [DATA_W-1:0]   r_shadow [NUM_CH];
    logic                r_shadow_vld;
    logic [31:0]         r_tick;
    logic                r_tick_pend;
    logic [31:0]         r_period;
    logic                r_enable;
    logic                r_irq_en;
    logic                r_ovf;
    logic                r_irq;
    logic                r_m_read;
    logic [31:0]         r_m_address;
    logic [31:0]         r_s_readdata;

    logic                w_en_rise;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic [EV_W-1:0]     w_fifo_dat;
    logic [31:0]         w_period_eff;
    logic                w_tick;
    logic                w_start;
    logic                w_last_ch;
    logic [CH_IDX_W-1:0] w_ch_next;
    logic [31:0]         w_next_addr;
    logic [31:0]         w_ev_word;
    logic                w_unused_rdata;

    assign m_read     = r_m_read;
    assign m_address  = r_m_address;
    assign s_readdata = r_s_readdata;
    assign irq        = r_irq;

    assign w_unused_rdata = ^m_readdata[31:DATA_W];

    assign w_en_rise = s_write && (s_address == CSR_CTRL) && s_writedata[0] && !r_enable;
    assign w_pop     = s_read && (s_address == CSR_EVENT) && !w_empty;
    assign w_push    = (r_state == ST_COMPARE) && r_shadow_vld && (r_sample != r_shadow[r_ch]);

    assign w_period_eff = (r_period == 32'd0) ? 32'd1 : r_period;
    assign w_tick       = (r_tick >= w_period_eff - 32'd1);
    assign w_start      = (r_state == ST_WAIT_TICK) && r_enable && (w_tick || r_tick_pend);

    assign w_last_ch   = (r_ch == CH_IDX_W'(NUM_CH - 1));
    assign w_ch_next   = r_ch + CH_IDX_W'(1);
    assign w_next_addr = BASE_ADDR + 32'(w_ch_next) * 32'(CH_STRIDE);
    assign w_ev_word   = ev_word(w_fifo_dat[EV_W-1:DATA_W], 32'(w_fifo_dat[DATA_W-1:0]));

    sbus_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_dat   ({EV_CH_W'(r_ch), r_sample}),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_dat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Free-running period counter; a wrap during a long sweep is remembered so the
    // next sweep starts as soon as the current one ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick      <= '0;
            r_tick_pend <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_tick      <= '0;
            r_tick_pend <= 1'b0;
        end else begin
            r_tick <= w_tick ? 32'd0 : r_tick + 32'd1;
            if (w_start) begin
                r_tick_pend <= 1'b0;
            end else if (w_tick) begin
                r_tick_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ch         <= '0;
            r_sample     <= '0;
            r_shadow_vld <= 1'b0;
            r_m_read     <= 1'b0;
            r_m_address  <= BASE_ADDR;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_m_read <= 1'b0;
                    if (r_enable) begin
                        r_state <= ST_WAIT_TICK;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!r_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_start) begin
                        r_state     <= ST_ISSUE;
                        r_ch        <= '0;
                        r_m_read    <= 1'b1;
                        r_m_address <= BASE_ADDR;
                    end
                end
                ST_ISSUE: begin
                    // A posted request must complete even if enable drops meanwhile.
                    if (!m_waitrequest) begin
                        r_m_read <= 1'b0;
                        r_state  <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (m_readdatavalid) begin
                        r_sample <= m_readdata[DATA_W-1:0];
                        r_state  <= r_enable ? ST_COMPARE : ST_IDLE;
                    end
                end
                ST_COMPARE: begin
                    r_shadow[r_ch] <= r_sample;
                    if (w_last_ch) begin
                        r_shadow_vld <= 1'b1;
                    end
                    if (!r_enable) begin
                        r_state <= ST_IDLE;
                    end else if (!w_last_ch) begin
                        r_state     <= ST_ISSUE;
                        r_ch        <= w_ch_next;
                        r_m_read    <= 1'b1;
                        r_m_address <= w_next_addr;
                    end else begin
                        r_state <= ST_WAIT_TICK;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_m_read <= 1'b0;
                end
            endcase
            if (w_en_rise) begin
                r_shadow_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable     <= 1'b0;
            r_irq_en     <= 1'b0;
            r_period     <= PERIOD_RST;
            r_ovf        <= 1'b0;
            r_irq        <= 1'b0;
            r_s_readdata <= '0;
        end else begin
            if (s_write && (s_address == CSR_CTRL)) begin
                r_enable <= s_writedata[0];
                r_irq_en <= s_writedata[1];
            end
            if (s_write && (s_address == CSR_PERIOD)) begin
                r_period <= s_writedata;
            end
            // A drop in the same cycle as the W1C keeps the flag set.
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (s_write && (s_address == CSR_STATUS) && s_writedata[1]) begin
                r_ovf <= 1'b0;
            end
            if (s_read) begin
                unique case (s_address)
                    CSR_CTRL:   r_s_readdata <= {30'h0, r_irq_en, r_enable};
                    CSR_STATUS: r_s_readdata <= (32'(w_count) << ST_COUNT_LSB)
                                                | {30'h0, r_ovf, !w_empty};
                    CSR_EVENT:  r_s_readdata <= w_empty ? 32'h0 : w_ev_word;
                    default:    r_s_readdata <= r_period;
                endcase
            end
            r_irq <= r_irq_en && !w_empty;
        end
    end

endmodule
